llc_cache: RTL and testbench

LLC_CACHE -- requirements
Module: llc_cache

---
 rtl/llc_cache.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_llc_cache.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/llc_cache.sv
// llc_cache: set-associative last-level cache with MESI line state, tree pseudo-LRU replacement,
// bus/snoop/L1 message outputs and a one-cycle evict step. Define LLC_DEBUG_EN for $display tracing.
module llc_cache #(
    parameter int unsigned SETS       = 16,
    parameter int unsigned WAYS       = 4,
    parameter int unsigned LINE_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  op,
    output logic [31:0] cacheRds,
    output logic [31:0] cacheWrs,
    output logic [31:0] cacheHits,
    output logic [31:0] cacheMisses,
    output logic [2:0]  busOp,
    output logic [1:0]  snoopResult,
    output logic [2:0]  message,
    output logic [1 + $clog2(WAYS) + 2 + (32 - $clog2(LINE_BYTES) - $clog2(SETS)) - 1:0] cache
);

    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
    localparam int unsigned PLRU_W = WAYS - 1;
    localparam int unsigned NODE_W = (PLRU_W > 1) ? $clog2(PLRU_W) : 1;

    localparam logic [3:0] OP_RD_D   = 4'd0;
    localparam logic [3:0] OP_WR_D   = 4'd1;
    localparam logic [3:0] OP_RD_I   = 4'd2;
    localparam logic [3:0] OP_SNP_RD = 4'd3;
    localparam logic [3:0] OP_SNP_WR = 4'd4;
    localparam logic [3:0] OP_SNP_RX = 4'd5;
    localparam logic [3:0] OP_SNP_IV = 4'd6;
    localparam logic [3:0] OP_IDLE   = 4'd7;
    localparam logic [3:0] OP_CLEAR  = 4'd8;
    localparam logic [3:0] OP_PRINT  = 4'd9;

    typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_e;
    typedef enum logic [2:0] {BUS_NOOP = 3'd0, BUS_READ = 3'd1, BUS_WRITE = 3'd2,
                              BUS_INVALIDATE = 3'd3, BUS_RWIM = 3'd4} bus_e;
    typedef enum logic [1:0] {SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2} snp_e;
    typedef enum logic [2:0] {MSG_NONE = 3'd0, MSG_GETLINE = 3'd1, MSG_SENDLINE = 3'd2,
                              MSG_INVALIDATELINE = 3'd3, MSG_EVICTLINE = 3'd4} msg_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_EVICT = 1'b1} fsm_e;

    typedef struct packed {
        logic             hit;
        logic [WAY_W-1:0] way;
        mesi_e            st;
        logic [TAG_W-1:0] tag;
    } line_info_t;

    fsm_e             state_q, state_d;
    mesi_e            mesi_q [SETS][WAYS];
    mesi_e            mesi_d [SETS][WAYS];
    logic [TAG_W-1:0] tag_q  [SETS][WAYS];
    logic [TAG_W-1:0] tag_d  [SETS][WAYS];
    logic [PLRU_W-1:0] plru_q [SETS];
    logic [PLRU_W-1:0] plru_d [SETS];
    logic [31:0]      rds_q, rds_d, wrs_q, wrs_d, hits_q, hits_d, misses_q, misses_d;
    bus_e             bus_op_q, bus_op_d;
    snp_e             snoop_q, snoop_d;
    msg_e             msg_q, msg_d;
    line_info_t       cache_q, cache_d;
    logic             pend_wr_q, pend_wr_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
    logic [WAY_W-1:0] pend_way_q, pend_way_d;
    snp_e             pend_snp_q, pend_snp_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit, has_inv, is_wr;
    logic [WAY_W-1:0] hit_way, inv_way, victim;
    mesi_e            cur_st, new_st, fill_st;
    snp_e             other;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^addr[OFF_W-1:2];

    // Tree walk: node bit 0 steers the victim left, 1 right; children of n are 2n+1 and 2n+2.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
        logic [WAY_W-1:0] w;
        int unsigned      node;
        logic             dir;
        w    = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir  = t[NODE_W'(node)];
            w    = WAY_W'({w, dir});
            node = 2 * node + 1 + 32'(dir);
        end
        return w;
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] r;
        logic [WAY_W-1:0]  w;
        int unsigned       node;
        logic              dir;
        r    = t;
        w    = way;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir                = w[WAY_W-1];
            r[NODE_W'(node)]   = ~dir;
            node               = 2 * node + 1 + 32'(dir);
            w                  = w << 1;
        end
        return r;
    endfunction

    // Other caches' response to our bus op, modelled from the low address bits.
    function automatic snp_e other_resp(input logic [1:0] a);
        if (a == 2'b00)      return SNP_HIT;
        else if (a == 2'b01) return SNP_HITM;
        else                 return SNP_NOHIT;
    endfunction

    // Lookup, victim choice and next-state / output computation.
    always_comb begin
        state_d    = state_q;
        mesi_d     = mesi_q;
        tag_d      = tag_q;
        plru_d     = plru_q;
        rds_d      = rds_q;
        wrs_d      = wrs_q;
        hits_d     = hits_q;
        misses_d   = misses_q;
        bus_op_d   = BUS_NOOP;
        snoop_d    = SNP_NOHIT;
        msg_d      = MSG_NONE;
        cache_d    = cache_q;
        pend_wr_d  = pend_wr_q;
        pend_idx_d = pend_idx_q;
        pend_tag_d = pend_tag_q;
        pend_way_d = pend_way_q;
        pend_snp_d = pend_snp_q;

        req_idx = addr[OFF_W +: IDX_W];
        req_tag = addr[31 -: TAG_W];
        other   = other_resp(addr[1:0]);
        is_wr   = (op == OP_WR_D);
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && mesi_q[req_idx][WAY_W'(w)] != MESI_I
                     && tag_q[req_idx][WAY_W'(w)] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mesi_q[req_idx][WAY_W'(w)] == MESI_I) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        victim  = plru_victim(plru_q[req_idx]);
        cur_st  = hit ? mesi_q[req_idx][hit_way] : MESI_I;
        new_st  = cur_st;
        fill_st = is_wr ? MESI_M : ((other == SNP_NOHIT) ? MESI_E : MESI_S);

        if (state_q == ST_EVICT) begin
            // Fill cycle: the op on the inputs this cycle is dropped.
            new_st = pend_wr_q ? MESI_M : ((pend_snp_q == SNP_NOHIT) ? MESI_E : MESI_S);
            mesi_d[pend_idx_q][pend_way_q] = new_st;
            tag_d[pend_idx_q][pend_way_q]  = pend_tag_q;
            plru_d[pend_idx_q] = plru_touch(plru_q[pend_idx_q], pend_way_q);
            bus_op_d = pend_wr_q ? BUS_RWIM : BUS_READ;
            snoop_d  = pend_snp_q;
            msg_d    = MSG_SENDLINE;
            cache_d  = '{hit: 1'b0, way: pend_way_q, st: new_st, tag: pend_tag_q};
            state_d  = ST_IDLE;
        end else begin
            case (op)
                OP_RD_D, OP_WR_D, OP_RD_I: begin
                    if (is_wr) wrs_d = wrs_q + 32'd1;
                    else       rds_d = rds_q + 32'd1;
                    snoop_d = other;
                    msg_d   = MSG_SENDLINE;
                    if (hit) begin
                        hits_d = hits_q + 32'd1;
                        plru_d[req_idx] = plru_touch(plru_q[req_idx], hit_way);
                        if (is_wr) begin
                            if (cur_st == MESI_S) bus_op_d = BUS_INVALIDATE;
                            new_st = MESI_M;
                        end
                        mesi_d[req_idx][hit_way] = new_st;
                        cache_d = '{hit: 1'b1, way: hit_way, st: new_st, tag: req_tag};
                    end else if (has_inv) begin
                        misses_d = misses_q + 32'd1;
                        mesi_d[req_idx][inv_way] = fill_st;
                        tag_d[req_idx][inv_way]  = req_tag;
                        plru_d[req_idx] = plru_touch(plru_q[req_idx], inv_way);
                        bus_op_d = is_wr ? BUS_RWIM : BUS_READ;
                        cache_d  = '{hit: 1'b0, way: inv_way, st: fill_st, tag: req_tag};
                    end else begin
                        misses_d = misses_q + 32'd1;
                        msg_d    = MSG_EVICTLINE;
                        bus_op_d = (mesi_q[req_idx][victim] == MESI_M) ? BUS_WRITE : BUS_NOOP;
                        mesi_d[req_idx][victim] = MESI_I;
                        cache_d    = '{hit: 1'b0, way: victim, st: MESI_I,
                                       tag: tag_q[req_idx][victim]};
                        pend_wr_d  = is_wr;
                        pend_idx_d = req_idx;
                        pend_tag_d = req_tag;
                        pend_way_d = victim;
                        pend_snp_d = other;
                        state_d    = ST_EVICT;
                    end
                end
                OP_SNP_RD: begin
                    if (hit) begin
                        snoop_d = (cur_st == MESI_M) ? SNP_HITM : SNP_HIT;
                        if (cur_st == MESI_M) begin
                            bus_op_d = BUS_WRITE;
                            msg_d    = MSG_GETLINE;
                        end
                        new_st = MESI_S;
                        mesi_d[req_idx][hit_way] = new_st;
                    end
                    cache_d = '{hit: hit, way: hit_way, st: new_st, tag: req_tag};
                end
                OP_SNP_WR: begin
                    cache_d = '{hit: hit, way: hit_way, st: cur_st, tag: req_tag};
                end
                OP_SNP_RX: begin
                    if (hit) begin
                        snoop_d = (cur_st == MESI_M) ? SNP_HITM : SNP_HIT;
                        if (cur_st == MESI_M) bus_op_d = BUS_WRITE;
                        msg_d  = MSG_INVALIDATELINE;
                        new_st = MESI_I;
                        mesi_d[req_idx][hit_way] = new_st;
                    end
                    cache_d = '{hit: hit, way: hit_way, st: new_st, tag: req_tag};
                end
                OP_SNP_IV: begin
                    if (hit && cur_st == MESI_S) begin
                        snoop_d = SNP_HIT;
                        msg_d   = MSG_INVALIDATELINE;
                        new_st  = MESI_I;
                        mesi_d[req_idx][hit_way] = new_st;
                    end
                    cache_d = '{hit: hit, way: hit_way, st: new_st, tag: req_tag};
                end
                OP_CLEAR: begin
                    mesi_d   = '{default: MESI_I};
                    tag_d    = '{default: '0};
                    plru_d   = '{default: '0};
                    rds_d    = '0;
                    wrs_d    = '0;
                    hits_d   = '0;
                    misses_d = '0;
                    cache_d  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mesi_q     <= '{default: MESI_I};
            tag_q      <= '{default: '0};
            plru_q     <= '{default: '0};
            rds_q      <= '0;
            wrs_q      <= '0;
            hits_q     <= '0;
            misses_q   <= '0;
            bus_op_q   <= BUS_NOOP;
            snoop_q    <= SNP_NOHIT;
            msg_q      <= MSG_NONE;
            cache_q    <= '0;
            pend_wr_q  <= 1'b0;
            pend_idx_q <= '0;
            pend_tag_q <= '0;
            pend_way_q <= '0;
            pend_snp_q <= SNP_NOHIT;
        end else begin
            state_q    <= state_d;
            mesi_q     <= mesi_d;
            tag_q      <= tag_d;
            plru_q     <= plru_d;
            rds_q      <= rds_d;
            wrs_q      <= wrs_d;
            hits_q     <= hits_d;
            misses_q   <= misses_d;
            bus_op_q   <= bus_op_d;
            snoop_q    <= snoop_d;
            msg_q      <= msg_d;
            cache_q    <= cache_d;
            pend_wr_q  <= pend_wr_d;
            pend_idx_q <= pend_idx_d;
            pend_tag_q <= pend_tag_d;
            pend_way_q <= pend_way_d;
            pend_snp_q <= pend_snp_d;
        end
    end

    assign cacheRds    = rds_q;
    assign cacheWrs    = wrs_q;
    assign cacheHits   = hits_q;
    assign cacheMisses = misses_q;
    assign busOp       = bus_op_q;
    assign snoopResult = snoop_q;
    assign message     = msg_q;
    assign cache       = cache_q;

`ifdef LLC_DEBUG_EN
    // Trace of accepted ops, plus a dump of valid lines on print.
    always @(posedge clk) begin
        if (!rst && state_q == ST_IDLE && op <= OP_PRINT && op != OP_IDLE) begin
            $display("llc op=%0d addr=%h busOp=%0d snoopResult=%0d message=%0d",
                     op, addr, bus_op_d, snoop_d, msg_d);
            if (op == OP_PRINT) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (mesi_q[IDX_W'(s)][WAY_W'(w)] != MESI_I)
                            $display("llc set=%0d way=%0d tag=%h mesi=%0d", s, w,
                                     tag_q[IDX_W'(s)][WAY_W'(w)], mesi_q[IDX_W'(s)][WAY_W'(w)]);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_llc_cache.sv
// Directed scoreboard bench for llc_cache (SETS=16, WAYS=4, 64-byte lines).
module tb_llc_cache;

    localparam int unsigned CW = 27;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [3:0]  op;
    logic [31:0] cacheRds, cacheWrs, cacheHits, cacheMisses;
    logic [2:0]  busOp;
    logic [1:0]  snoopResult;
    logic [2:0]  message;
    logic [CW-1:0] cache;

    llc_cache #(.SETS(16), .WAYS(4), .LINE_BYTES(64)) dut (
        .clk(clk), .rst(rst), .addr(addr), .op(op),
        .cacheRds(cacheRds), .cacheWrs(cacheWrs), .cacheHits(cacheHits),
        .cacheMisses(cacheMisses), .busOp(busOp), .snoopResult(snoopResult),
        .message(message), .cache(cache)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    bus;
        logic [1:0]    snp;
        logic [2:0]    msg;
        logic [CW-1:0] line;
        logic [31:0]   rds;
        logic [31:0]   wrs;
        logic [31:0]   hits;
        logic [31:0]   misses;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_vec  = 0;
    int unsigned n_bad  = 0;
    int unsigned vec_id = 0;
    logic [31:0] m_rds = 0, m_wrs = 0, m_hits = 0, m_misses = 0;

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic apply(input logic r, input logic [3:0] o, input logic [31:0] a,
                         input logic [2:0] b, input logic [1:0] s, input logic [2:0] m,
                         input logic h, input logic [1:0] w, input logic [1:0] st,
                         input logic [21:0] t, input logic cnt);
        exp_t e;
        @(negedge clk);
        rst  = r;
        op   = o;
        addr = a;
        if (r || o == 4'd8) begin
            m_rds = 0; m_wrs = 0; m_hits = 0; m_misses = 0;
        end else if (cnt) begin
            if (o == 4'd1) m_wrs = m_wrs + 1;
            else           m_rds = m_rds + 1;
            if (h) m_hits = m_hits + 1;
            else   m_misses = m_misses + 1;
        end
        e.bus    = b;
        e.snp    = s;
        e.msg    = m;
        e.line   = {h, w, st, t};
        e.rds    = m_rds;
        e.wrs    = m_wrs;
        e.hits   = m_hits;
        e.misses = m_misses;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the registered outputs just after each edge that has an expectation.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e   = sb_q.pop_front();
                got = {busOp, snoopResult, message, cache, cacheRds, cacheWrs, cacheHits, cacheMisses};
                n_vec++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL vec%0d: got bus=%0d snp=%0d msg=%0d cache=%h rds=%0d wrs=%0d hits=%0d miss=%0d; want bus=%0d snp=%0d msg=%0d cache=%h rds=%0d wrs=%0d hits=%0d miss=%0d",
                             vec_id, got.bus, got.snp, got.msg, got.line, got.rds, got.wrs, got.hits, got.misses,
                             e.bus, e.snp, e.msg, e.line, e.rds, e.wrs, e.hits, e.misses);
                end
                vec_id++;
            end
        end
    end

    initial begin
        rst  = 1'b1;
        op   = 4'd7;
        addr = '0;
        //    rst op  addr          bus snp msg  hit way st tag       cnt
        apply(1, 7, 32'h0,          0, 0, 0,   0, 0, 0, 22'h0,  0);
        apply(0, 0, 32'h00001002,   1, 0, 2,   0, 0, 2, 22'h4,  1);
        apply(0, 0, 32'h00001002,   0, 0, 2,   1, 0, 2, 22'h4,  1);
        apply(0, 7, 32'h0,          0, 0, 0,   1, 0, 2, 22'h4,  0);
        apply(0, 1, 32'h00001002,   0, 0, 2,   1, 0, 3, 22'h4,  1);
        apply(0, 3, 32'h00001002,   2, 2, 1,   1, 0, 1, 22'h4,  0);
        apply(0, 0, 32'h00002000,   1, 1, 2,   0, 1, 1, 22'h8,  1);
        apply(0, 1, 32'h00002000,   3, 1, 2,   1, 1, 3, 22'h8,  1);
        apply(0, 4, 32'h00002000,   0, 0, 0,   1, 1, 3, 22'h8,  0);
        apply(0, 6, 32'h00002000,   0, 0, 0,   1, 1, 3, 22'h8,  0);
        apply(0, 6, 32'h00001002,   0, 1, 3,   1, 0, 0, 22'h4,  0);
        apply(0, 3, 32'h00001002,   0, 0, 0,   0, 0, 0, 22'h4,  0);
        apply(0, 8, 32'h0,          0, 0, 0,   0, 0, 0, 22'h0,  0);
        // Four write misses fill set 0, the fifth evicts way 0 then fills it.
        apply(0, 1, 32'h00000400,   4, 1, 2,   0, 0, 3, 22'h1,  1);
        apply(0, 1, 32'h00000800,   4, 1, 2,   0, 1, 3, 22'h2,  1);
        apply(0, 1, 32'h00000C00,   4, 1, 2,   0, 2, 3, 22'h3,  1);
        apply(0, 1, 32'h00001000,   4, 1, 2,   0, 3, 3, 22'h4,  1);
        apply(0, 1, 32'h00001400,   2, 1, 4,   0, 0, 0, 22'h1,  1);
        apply(0, 0, 32'h00000400,   4, 1, 2,   0, 0, 3, 22'h5,  0);
        apply(0, 0, 32'h00000400,   2, 1, 4,   0, 2, 0, 22'h3,  1);
        apply(0, 7, 32'h0,          1, 1, 2,   0, 2, 1, 22'h1,  0);
        apply(0, 5, 32'h00000400,   0, 1, 3,   1, 2, 0, 22'h1,  0);
        apply(0, 5, 32'h00001400,   2, 2, 3,   1, 0, 0, 22'h5,  0);
        apply(0, 3, 32'h00000800,   2, 2, 1,   1, 1, 1, 22'h2,  0);
        apply(0, 8, 32'h0,          0, 0, 0,   0, 0, 0, 22'h0,  0);
        apply(0, 0, 32'h00000400,   1, 1, 2,   0, 0, 1, 22'h1,  1);
        apply(0, 2, 32'h00010042,   1, 0, 2,   0, 0, 2, 22'h40, 1);
        apply(0, 3, 32'h00010040,   0, 1, 0,   1, 0, 1, 22'h40, 0);
        apply(0, 3, 32'h00010040,   0, 1, 0,   1, 0, 1, 22'h40, 0);
        apply(0, 9, 32'h0,          0, 0, 0,   1, 0, 1, 22'h40, 0);
        apply(0, 0, 32'h00010041,   0, 2, 2,   1, 0, 1, 22'h40, 1);
        apply(0, 15, 32'h0,         0, 0, 0,   1, 0, 1, 22'h40, 0);
        // Fill set 0 with clean lines, force an evict, then reset during the fill cycle.
        apply(0, 0, 32'h00000800,   1, 1, 2,   0, 1, 1, 22'h2,  1);
        apply(0, 0, 32'h00000C00,   1, 1, 2,   0, 2, 1, 22'h3,  1);
        apply(0, 0, 32'h00001000,   1, 1, 2,   0, 3, 1, 22'h4,  1);
        apply(0, 0, 32'h00001402,   0, 0, 4,   0, 0, 0, 22'h1,  1);
        apply(1, 7, 32'h0,          0, 0, 0,   0, 0, 0, 22'h0,  0);
        apply(0, 0, 32'h00001402,   1, 0, 2,   0, 0, 2, 22'h5,  1);
        apply(0, 7, 32'h0,          0, 0, 0,   0, 0, 2, 22'h5,  0);

        @(negedge clk);
        rst = 1'b0;
        op  = 4'd7;
        repeat (3) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
